// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    // Memory-wait FSM state
    typedef logic [1:0] state_t;
    localparam state_t StRun     = 2'd0;
    localparam state_t StMemWait = 2'd1;
    localparam state_t StErr     = 2'd2;

    // ResultSrc value marking a load in Execute
    localparam logic [1:0] ResultSrcLoad = 2'b01;

    // Operand forward-select encodings
    localparam logic [1:0] FwdRf  = 2'b00;
    localparam logic [1:0] FwdWb  = 2'b01;
    localparam logic [1:0] FwdMem = 2'b10;

    // Default data-memory wait budget before declaring an error
    localparam int unsigned MemTimeoutDefault = 16;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand bypass select for one Execute-stage source register.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    // Memory stage is the younger producer, so it wins over Writeback
    always_comb begin
        fwd_o = FwdRf;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FwdMem;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FwdWb;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch handling and
// data-memory wait tracking with a sticky timeout error.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       Rd_M,
    input  logic             RegWriteM,
    input  logic [4:0]       Rd_W,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mem_stall;
    logic               load_use;
    logic [1:0]         fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .rs_e_i        (Rs1_E),
        .rd_m_i        (Rd_M),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (Rd_W),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e_i        (Rs2_E),
        .rd_m_i        (Rd_M),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (Rd_W),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign load_use = (ResultSrcE == ResultSrcLoad) && (Rd_E != 5'd0) &&
                      ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // Memory-wait FSM next state; the first stalled cycle happens in RUN and counts as wait 1
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        case (state_q)
            StRun: begin
                mem_stall = MemReqM && !MemReadyM;
                if (mem_stall) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                mem_stall = !MemReadyM;
                if (MemReadyM) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                    if (wait_cnt_q >= WaitW'(MEM_TIMEOUT - 1)) begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                mem_stall = 1'b0;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stall/flush priority: reset, memory wait or error, taken branch, load-use
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (RST) begin
            StallF = 1'b0;
        end else if (mem_stall || (state_q == StErr)) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ForwardAE = RST ? FwdRf : fwd_a;
    assign ForwardBE = RST ? FwdRf : fwd_b;
    assign MemErr    = (state_q == StErr);
    assign StallCnt  = stall_cnt_q;

endmodule
